// File: rtl/fact_host_if.sv
// Client-side job/response handshake and peripheral register bus for fact_host.
// The master modport is the sequencer's view; slave is the client/peripheral side.
interface fact_host_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_n;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_nf;
    logic        resp_err;
    logic        resp_timeout;
    logic        busy;
    logic [1:0]  bus_a;
    logic        bus_we;
    logic [3:0]  bus_wd;
    logic [31:0] bus_rd;

    modport master (
        input  req_valid, req_n, resp_ready, bus_rd,
        output req_ready, resp_valid, resp_nf, resp_err, resp_timeout, busy,
               bus_a, bus_we, bus_wd
    );

    modport slave (
        output req_valid, req_n, resp_ready, bus_rd,
        input  req_ready, resp_valid, resp_nf, resp_err, resp_timeout, busy,
               bus_a, bus_we, bus_wd
    );
endinterface

// File: rtl/fact_host.sv
// Bus-initiator sequencer: runs write n / pulse go / poll status / read nf / clear go
// against the 4-word factorial peripheral and returns the result on a handshake port.
module fact_host #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 13
) (
    input  logic       clk,
    input  logic       rst,
    fact_host_if.master fh
);

    typedef enum logic [2:0] {
        IDLE, WR_N, WR_GO, SETTLE, POLL, RD_RES, CLR_GO, RESP
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [3:0]       n_q, n_d;
    logic [31:0]      nf_q, nf_d;
    logic             err_q, err_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            nf_q    <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            nf_q    <= nf_d;
            err_q   <= err_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        nf_d    = nf_q;
        err_d   = err_q;
        to_d    = to_q;
        cnt_d   = cnt_q;

        fh.req_ready    = 1'b0;
        fh.resp_valid   = 1'b0;
        fh.resp_nf      = '0;
        fh.resp_err     = 1'b0;
        fh.resp_timeout = 1'b0;
        fh.busy         = (state_q != IDLE);
        fh.bus_a        = 2'd0;
        fh.bus_we       = 1'b0;
        fh.bus_wd       = '0;

        case (state_q)
            IDLE: begin
                fh.req_ready = 1'b1;
                if (fh.req_valid) begin
                    n_d     = fh.req_n;
                    state_d = WR_N;
                end
            end
            WR_N: begin
                fh.bus_a  = 2'd0;
                fh.bus_we = 1'b1;
                fh.bus_wd = n_q;
                state_d   = WR_GO;
            end
            WR_GO: begin
                fh.bus_a  = 2'd1;
                fh.bus_we = 1'b1;
                fh.bus_wd = 4'b0001;
                state_d   = SETTLE;
            end
            SETTLE: begin
                // status still reflects the previous job here, so it is not sampled
                fh.bus_a = 2'd2;
                cnt_d    = '0;
                state_d  = POLL;
            end
            POLL: begin
                fh.bus_a = 2'd2;
                cnt_d    = cnt_q + 1'b1;
                if (fh.bus_rd[1]) begin
                    err_d   = 1'b1;
                    state_d = CLR_GO;
                end else if (fh.bus_rd[0]) begin
                    state_d = RD_RES;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = CLR_GO;
                end
            end
            RD_RES: begin
                fh.bus_a = 2'd3;
                nf_d     = fh.bus_rd;
                state_d  = CLR_GO;
            end
            CLR_GO: begin
                fh.bus_a  = 2'd1;
                fh.bus_we = 1'b1;
                fh.bus_wd = 4'b0000;
                state_d   = RESP;
            end
            RESP: begin
                fh.resp_valid   = 1'b1;
                fh.resp_nf      = (err_q || to_q) ? '0 : nf_q;
                fh.resp_err     = err_q;
                fh.resp_timeout = to_q;
                if (fh.resp_ready) begin
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    nf_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fact_host.sv
// Directed bench for fact_host: behavioural factorial peripheral, per-job transaction
// model (writes, reads, latency, result) and a single per-cycle compare process.
module tb_fact_host;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fact_host_if fi ();

    fact_host #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .fh  (fi.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r = 32'd1;
        for (int unsigned i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    // Peripheral: done (or err when n>12) becomes visible 2+n cycles after the go write.
    bit          never_done = 1'b0;
    logic [3:0]  p_n;
    logic        p_go;
    logic [1:0]  p_st;
    logic [31:0] p_nf;
    int          p_cd;

    always @(posedge clk) begin
        if (rst) begin
            p_n <= '0; p_go <= 1'b0; p_st <= '0; p_nf <= '0; p_cd <= 0;
        end else if (fi.bus_we) begin
            if (fi.bus_a == 2'd0) p_n <= fi.bus_wd;
            if (fi.bus_a == 2'd1) begin
                p_go <= fi.bus_wd[0];
                if (fi.bus_wd[0]) begin
                    p_st <= '0;
                    p_cd <= 2 + int'(p_n);
                end
            end
        end else if (p_cd > 0) begin
            p_cd <= p_cd - 1;
            if (p_cd == 1 && !never_done) begin
                p_st <= (p_n > 4'd12) ? 2'b10 : 2'b01;
                p_nf <= fact(p_n);
            end
        end
    end

    always_comb begin
        case (fi.bus_a)
            2'd0:    fi.bus_rd = {28'd0, p_n};
            2'd1:    fi.bus_rd = {31'd0, p_go};
            2'd2:    fi.bus_rd = 32'hDEAD_BEEC | {30'd0, p_st};
            default: fi.bus_rd = p_nf;
        endcase
    end

    // Per-job expectations and observations
    int          cyc = 0;
    bit          pend = 1'b0;
    bit          prev_v = 1'b0;
    int          acc_cyc;
    logic [3:0]  e_n;
    logic [31:0] e_nf;
    logic        e_err, e_to, e_ok;
    int          e_lat, e_polls;
    logic [5:0]  wlog[$];
    int          rd3, a2;
    logic [33:0] held;
    int          resp_cnt = 0;
    logic [31:0] last_nf;
    logic        last_err, last_to;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend = 1'b0; prev_v = 1'b0; wlog.delete(); rd3 = 0; a2 = 0;
        end else begin
            chk("ready_vs_busy", fi.req_ready, !fi.busy);
            if (fi.bus_we) wlog.push_back({fi.bus_a, fi.bus_wd});
            if (fi.busy && !fi.bus_we && fi.bus_a == 2'd3) rd3++;
            if (fi.busy && !fi.bus_we && fi.bus_a == 2'd2) a2++;
            if (fi.resp_valid) begin
                if (!prev_v) begin
                    chk("resp_pending", pend, 1);
                    chk("resp_latency", cyc - acc_cyc, e_lat);
                    chk("resp_nf", fi.resp_nf, e_nf);
                    chk("resp_err", fi.resp_err, e_err);
                    chk("resp_timeout", fi.resp_timeout, e_to);
                    held = {fi.resp_nf, fi.resp_err, fi.resp_timeout};
                end else begin
                    chk("resp_stable", {fi.resp_nf, fi.resp_err, fi.resp_timeout}, held);
                end
                if (fi.resp_ready) begin
                    chk("num_writes", wlog.size(), 3);
                    if (wlog.size() == 3) begin
                        chk("wr_n", wlog[0], {2'd0, e_n});
                        chk("wr_go", wlog[1], 6'b01_0001);
                        chk("wr_clr", wlog[2], 6'b01_0000);
                    end
                    chk("rd_res_cycles", rd3, e_ok ? 1 : 0);
                    chk("status_cycles", a2, e_polls + 1);
                    last_nf = fi.resp_nf; last_err = fi.resp_err; last_to = fi.resp_timeout;
                    pend = 1'b0;
                    resp_cnt++;
                end
            end
            prev_v = fi.resp_valid;
            if (fi.req_valid && fi.req_ready) begin
                chk("accept_when_free", pend, 0);
                pend = 1'b1; acc_cyc = cyc; e_n = fi.req_n;
                wlog.delete(); rd3 = 0; a2 = 0;
                e_err = 1'b0; e_to = 1'b0; e_ok = 1'b0; e_nf = '0;
                if (never_done) begin
                    e_to = 1'b1; e_polls = 16; e_lat = 5 + 16;
                end else if (fi.req_n > 4'd12) begin
                    e_err = 1'b1; e_polls = int'(fi.req_n) + 2; e_lat = 5 + e_polls;
                end else begin
                    e_ok = 1'b1; e_nf = fact(fi.req_n);
                    e_polls = int'(fi.req_n) + 2; e_lat = 6 + e_polls;
                end
            end
        end
    end

    task automatic send(input logic [3:0] n);
        int t = 0;
        @(posedge clk); #1;
        fi.req_n = n; fi.req_valid = 1'b1;
        while (!fi.req_ready && t < 60) begin @(posedge clk); #1; t++; end
        chk("req_accept", fi.req_ready, 1);
        @(posedge clk); #1;
        fi.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int c0);
        int t = 0;
        while (resp_cnt == c0 && t < 100) begin @(posedge clk); #1; t++; end
        chk("resp_wait", resp_cnt, c0 + 1);
    endtask

    task automatic chk_idle(input string name);
        chk(name, {fi.bus_we, fi.bus_a, fi.bus_wd, fi.resp_valid, fi.resp_nf,
                   fi.resp_err, fi.resp_timeout, fi.busy, fi.req_ready},
                  {1'b0, 2'd0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t;
        rst = 1'b1; fi.req_valid = 1'b0; fi.req_n = '0; fi.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("reset_outputs");

        // basic job
        c = resp_cnt; send(4'd5); wait_resp(c);
        chk("nf_5", last_nf, 32'd120);
        chk("err_5", {last_err, last_to}, 2'b00);

        // n=12 then n=0 with req_valid held through RESP
        c = resp_cnt;
        @(posedge clk); #1; fi.req_n = 4'd12; fi.req_valid = 1'b1;
        t = 0;
        while (!fi.req_ready && t < 60) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1; fi.req_n = 4'd0;
        wait_resp(c);
        chk("nf_12", last_nf, 32'd479001600);
        @(posedge clk); #1; fi.req_valid = 1'b0;
        wait_resp(c + 1);
        chk("nf_0", last_nf, 32'd1);

        // peripheral error
        c = resp_cnt; send(4'd13); wait_resp(c);
        chk("err_13", {last_err, last_to, last_nf}, {1'b1, 1'b0, 32'd0});

        // timeout
        never_done = 1'b1;
        c = resp_cnt; send(4'd2); wait_resp(c);
        chk("timeout", {last_err, last_to, last_nf}, {1'b0, 1'b1, 32'd0});
        never_done = 1'b0;

        // stalled response, requests ignored meanwhile
        fi.resp_ready = 1'b0;
        c = resp_cnt; send(4'd4);
        t = 0;
        while (!fi.resp_valid && t < 60) begin @(posedge clk); #1; t++; end
        chk("stall_resp_seen", fi.resp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            fi.req_valid = i[0]; fi.req_n = 4'd9;
            chk("stall_req_ready", fi.req_ready, 0);
        end
        fi.req_valid = 1'b0; fi.resp_ready = 1'b1;
        wait_resp(c);
        chk("nf_4", last_nf, 32'd24);

        // reset while polling
        c = resp_cnt; send(4'd7);
        t = 0;
        while (t < 40 && a2 < 4) begin @(posedge clk); #1; t++; end
        chk("reached_poll", fi.bus_a, 2'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle("rst_in_poll");
        rst = 1'b0;
        c = resp_cnt; send(4'd3); wait_resp(c);
        chk("nf_3", last_nf, 32'd6);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
